// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam int PORT_CPU      = 0;
  localparam int PORT_LDR      = 1;
  localparam int DEFAULT_DEPTH = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input grant logic with a priority pointer.
// Build option: DMEM_ARB_RR_EN selects round-robin; otherwise port 0 always wins.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic prio;       // 1: port 1 is preferred on contention
  logic prio_next;

  always_comb begin
    if (prio) begin
      grant[1] = req[1];
      grant[0] = req[0] & ~req[1];
    end else begin
      grant[0] = req[0];
      grant[1] = req[1] & ~req[0];
    end
  end

`ifdef DMEM_ARB_RR_EN
  // After serving port 0, port 1 gets preference, and vice versa.
  assign prio_next = grant[0];
`else
  assign prio_next = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (advance) begin
      prio <= prio_next;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer in front of a single-port synchronous data memory.
// Build option: DMEM_ARB_RR_EN enables round-robin arbitration (see rr_arbiter2).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic              req0_we_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_wdata_i,
  output logic              rsp0_valid_o,
  output logic [DATA_W-1:0] rsp0_rdata_o,
  output logic              rsp0_err_o,

  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic              req1_we_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_wdata_i,
  output logic              rsp1_valid_o,
  output logic [DATA_W-1:0] rsp1_rdata_o,
  output logic              rsp1_err_o,

  output logic              mem_we_o,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  state_e            state, state_next;
  logic [1:0]        req_gated;
  logic [1:0]        grant;
  logic              handshake;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              port_q;
  logic              err_q;
  logic              in_range;

  // Requests are only offered in IDLE; gating with rst_n keeps ready low while reset is held.
  assign req_gated = {req1_valid_i, req0_valid_i} & {2{rst_n && (state == IDLE)}};
  assign handshake = |grant;
  assign in_range  = (addr_q < ADDR_W'(DEPTH));

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_gated),
    .advance (handshake),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: capture registers are reset too, so a dropped transaction leaves no stale payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      port_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (handshake) begin
        we_q    <= grant[1] ? req1_we_i    : req0_we_i;
        addr_q  <= grant[1] ? req1_addr_i  : req0_addr_i;
        wdata_q <= grant[1] ? req1_wdata_i : req0_wdata_i;
        port_q  <= grant[1] ? 1'(PORT_LDR) : 1'(PORT_CPU);
      end
      if (state == ACCESS) begin
        err_q <= !in_range;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (handshake) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    req0_ready_o = grant[0];
    req1_ready_o = grant[1];
    rsp0_valid_o = 1'b0;
    rsp0_rdata_o = '0;
    rsp0_err_o   = 1'b0;
    rsp1_valid_o = 1'b0;
    rsp1_rdata_o = '0;
    rsp1_err_o   = 1'b0;
    mem_we_o     = 1'b0;
    mem_re_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    case (state)
      ACCESS: begin
        if (in_range) begin
          mem_we_o    = we_q;
          mem_re_o    = !we_q;
          mem_addr_o  = addr_q;
          mem_wdata_o = wdata_q;
        end
      end
      RESP: begin
        if (port_q == 1'(PORT_LDR)) begin
          rsp1_valid_o = 1'b1;
          rsp1_err_o   = err_q;
          rsp1_rdata_o = (we_q || err_q) ? '0 : mem_rdata_i;
        end else begin
          rsp0_valid_o = 1'b1;
          rsp0_err_o   = err_q;
          rsp0_rdata_o = (we_q || err_q) ? '0 : mem_rdata_i;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level model plus directed vectors.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid_i, req0_ready_o, req0_we_i;
  logic [31:0] req0_addr_i, req0_wdata_i;
  logic        rsp0_valid_o, rsp0_err_o;
  logic [31:0] rsp0_rdata_o;
  logic        req1_valid_i, req1_ready_o, req1_we_i;
  logic [31:0] req1_addr_i, req1_wdata_i;
  logic        rsp1_valid_o, rsp1_err_o;
  logic [31:0] rsp1_rdata_o;
  logic        mem_we_o, mem_re_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hs_cyc;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_we_i(req0_we_i),
    .req0_addr_i(req0_addr_i), .req0_wdata_i(req0_wdata_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_rdata_o(rsp0_rdata_o), .rsp0_err_o(rsp0_err_o),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_we_i(req1_we_i),
    .req1_addr_i(req1_addr_i), .req1_wdata_i(req1_wdata_i),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_rdata_o(rsp1_rdata_o), .rsp1_err_o(rsp1_err_o),
    .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Data_Memory stand-in: 8 words, synchronous read and write.
  logic [31:0] stub [8];
  always @(posedge clk) begin
    if (mem_we_o && mem_addr_o < 8) stub[mem_addr_o[2:0]] <= mem_wdata_o;
    if (mem_re_o) mem_rdata_i <= stub[mem_addr_o[2:0]];
  end

  // Transaction model: age 0 = free, 1 = strobe cycle, 2 = response cycle.
  int          m_age, m_port, m_last;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] shadow [8];

  function automatic int pick(input logic v0, input logic v1, input int last);
`ifdef DMEM_ARB_RR_EN
    if (v0 && v1) return (last == 0) ? 1 : 0;
`endif
    return v0 ? 0 : 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int w;
    if (!rst_n) begin
      m_age  <= 0;
      m_last <= 1;
    end else if (m_age == 0) begin
      if (req0_valid_i || req1_valid_i) begin
        w = pick(req0_valid_i, req1_valid_i, m_last);
        m_port  <= w;
        m_last  <= w;
        m_we    <= (w == 1) ? req1_we_i    : req0_we_i;
        m_addr  <= (w == 1) ? req1_addr_i  : req0_addr_i;
        m_wdata <= (w == 1) ? req1_wdata_i : req0_wdata_i;
        m_age   <= 1;
      end
    end else if (m_age == 1) begin
      if (m_we && m_addr < 8) shadow[m_addr[2:0]] <= m_wdata;
      m_age <= 2;
    end else begin
      m_age <= 0;
    end
  end

  always @(negedge clk) begin : compare
    logic        e_r0, e_r1, e_v0, e_v1, e_err0, e_err1, e_we, e_re;
    logic [31:0] e_rd0, e_rd1, e_addr, e_wd;
    int          w;
    e_r0 = 0; e_r1 = 0; e_v0 = 0; e_v1 = 0; e_err0 = 0; e_err1 = 0; e_we = 0; e_re = 0;
    e_rd0 = 0; e_rd1 = 0; e_addr = 0; e_wd = 0;
    if (rst_n) begin
      if (m_age == 0) begin
        if (req0_valid_i || req1_valid_i) begin
          w = pick(req0_valid_i, req1_valid_i, m_last);
          e_r0 = (w == 0);
          e_r1 = (w == 1);
        end
      end else if (m_age == 1) begin
        if (m_addr < 8) begin
          e_we = m_we; e_re = !m_we; e_addr = m_addr; e_wd = m_wdata;
        end
      end else if (m_port == 0) begin
        e_v0 = 1; e_err0 = (m_addr >= 8);
        e_rd0 = (!m_we && m_addr < 8) ? shadow[m_addr[2:0]] : 32'h0;
      end else begin
        e_v1 = 1; e_err1 = (m_addr >= 8);
        e_rd1 = (!m_we && m_addr < 8) ? shadow[m_addr[2:0]] : 32'h0;
      end
    end
    check("m_ready0", req0_ready_o, e_r0);
    check("m_ready1", req1_ready_o, e_r1);
    check("m_rsp0_valid", rsp0_valid_o, e_v0);
    check("m_rsp1_valid", rsp1_valid_o, e_v1);
    check("m_rsp0_err", rsp0_err_o, e_err0);
    check("m_rsp1_err", rsp1_err_o, e_err1);
    check("m_rsp0_rdata", rsp0_rdata_o, e_rd0);
    check("m_rsp1_rdata", rsp1_rdata_o, e_rd1);
    check("m_mem_we", mem_we_o, e_we);
    check("m_mem_re", mem_re_o, e_re);
    check("m_mem_addr", mem_addr_o, e_addr);
    check("m_mem_wdata", mem_wdata_o, e_wd);
  end

  task automatic set_req(input int p, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      req0_valid_i = v; req0_we_i = we; req0_addr_i = a; req0_wdata_i = d;
    end else begin
      req1_valid_i = v; req1_we_i = we; req1_addr_i = a; req1_wdata_i = d;
    end
  endtask

  // Waits (bounded) for a handshake; returns just after its edge, i.e. in the strobe cycle.
  task automatic wait_hs(output int port);
    port = -1;
    for (int i = 0; i < 30 && port < 0; i++) begin
      @(negedge clk);
      if (req0_valid_i && req0_ready_o) port = 0;
      else if (req1_valid_i && req1_ready_o) port = 1;
    end
    check("hs_seen", (port >= 0), 1);
    if (port >= 0) begin
      @(posedge clk);
      hs_cyc = cyc;
      #1;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, prev;
    int order [4];
    int exp_order [4];
    rst_n = 0;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      stub[i]   = 32'h100 + i;
      shadow[i] = 32'h100 + i;
    end
    stub[3]   = 32'hDEADBEEF;
    shadow[3] = 32'hDEADBEEF;
    mem_rdata_i = 0;

    #12;
    check("rst_ctrl", {req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o,
                       rsp0_err_o, rsp1_err_o, mem_we_o, mem_re_o}, 0);
    check("rst_bus", |{rsp0_rdata_o, rsp1_rdata_o, mem_addr_o, mem_wdata_o}, 0);
    #11 rst_n = 1;
    next_cycle();

    // Single read of addr 3.
    set_req(0, 1, 0, 3, 0);
    wait_hs(p);
    check("rd_port", p, 0);
    set_req(0, 0, 0, 0, 0);
    check("rd_strobe", {mem_re_o, mem_we_o}, 2'b10);
    check("rd_addr", mem_addr_o, 3);
    next_cycle();
    check("rd_rsp", {rsp0_valid_o, rsp0_err_o, rsp1_valid_o}, 3'b100);
    check("rd_data", rsp0_rdata_o, 32'hDEADBEEF);
    next_cycle();

    // Port 1 writes then reads addr 5.
    set_req(1, 1, 1, 5, 32'h12345678);
    wait_hs(p);
    check("wr_port", p, 1);
    set_req(1, 0, 0, 0, 0);
    check("wr_strobe", {mem_we_o, mem_re_o}, 2'b10);
    check("wr_bus", {mem_addr_o, mem_wdata_o}, {32'd5, 32'h12345678});
    next_cycle();
    check("wr_rsp", {rsp1_valid_o, rsp1_err_o, rsp1_rdata_o}, {2'b10, 32'h0});
    set_req(1, 1, 0, 5, 0);
    wait_hs(p);
    set_req(1, 0, 0, 0, 0);
    next_cycle();
    check("wr_readback", rsp1_rdata_o, 32'h12345678);

    // Out-of-range read at addr 8, then a handshake at T+3.
    set_req(0, 1, 0, 8, 0);
    wait_hs(p);
    prev = hs_cyc;
    set_req(0, 0, 0, 0, 0);
    check("oor_strobe", {mem_we_o, mem_re_o}, 2'b00);
    next_cycle();
    check("oor_rsp", {rsp0_valid_o, rsp0_err_o, rsp0_rdata_o}, {2'b11, 32'h0});
    set_req(0, 1, 0, 0, 0);
    next_cycle();
    check("oor_idle_ready", req0_ready_o, 1);
    wait_hs(p);
    check("oor_next_hs", hs_cyc - prev, 3);
    set_req(0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();

    // Back-to-back reads on port 0.
    set_req(0, 1, 0, 3, 0);
    prev = -1;
    for (int i = 0; i < 3; i++) begin
      wait_hs(p);
      check("b2b_access_ready", req0_ready_o, 0);
      if (prev >= 0) check("b2b_spacing", hs_cyc - prev, 3);
      prev = hs_cyc;
    end
    set_req(0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();

    // Port 0 read, reset during ACCESS with both ports requesting.
    set_req(0, 1, 0, 4, 0);
    wait_hs(p);
    set_req(1, 1, 0, 2, 0);
    set_req(0, 1, 0, 1, 0);
    #2 rst_n = 0;
    #1;
    check("midrst_ctrl", {req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o,
                          rsp0_err_o, rsp1_err_o, mem_we_o, mem_re_o}, 0);
    check("midrst_bus", |{rsp0_rdata_o, rsp1_rdata_o, mem_addr_o, mem_wdata_o}, 0);
    next_cycle();
    next_cycle();
    #2 rst_n = 1;
    #1;
    check("post_rst_rsp", {rsp0_valid_o, rsp1_valid_o}, 2'b00);
    check("post_rst_ready", {req0_ready_o, req1_ready_o}, 2'b10);

    // Contention over four transactions.
    for (int i = 0; i < 4; i++) begin
      wait_hs(p);
      order[i] = p;
    end
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
`ifdef DMEM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) check($sformatf("grant_order_%0d", i), order[i], exp_order[i]);
    repeat (4) next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer in front of the single-port `Data_Memory` (8 × 32-bit, synchronous read/write). It accepts load/store requests from the pipeline MEM stage (port 0) and from the program/data loader (port 1) over valid/ready handshakes. It serialises them onto the memory's `MemWrite_i`/`MemRead_i`/`addr_i`/`data_i` strobes and returns one response per request with the registered read data.

## Interface
- `ADDR_W`, default 32: request address width.
- `DATA_W`, default 32: data width.
- `DEPTH`, default 8: number of memory words. Word index `addr` is legal iff `addr < DEPTH`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid_i` in 1, `req0_ready_o` out 1: port-0 handshake.
- `req0_we_i` in 1: port-0 write request when 1, read request when 0.
- `req0_addr_i` in ADDR_W: port-0 word address.
- `req0_wdata_i` in DATA_W: port-0 write data.
- `rsp0_valid_o` out 1, `rsp0_rdata_o` out DATA_W, `rsp0_err_o` out 1: port-0 response.
- `req1_*` / `rsp1_*`: identical set for port 1.
- `mem_we_o` out 1: drives `MemWrite_i`.
- `mem_re_o` out 1: drives `MemRead_i`.
- `mem_addr_o` out ADDR_W: drives `addr_i`.
- `mem_wdata_o` out DATA_W: drives memory `data_i`.
- `mem_rdata_i` in DATA_W: memory `data_o`, valid one cycle after `mem_re_o`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - If any `reqN_valid_i` is high, the arbiter picks a winner. `reqN_ready_o` is high only for the winner, combinationally.
  - On the handshake, the block captures `we`, `addr`, `wdata` and the port ID, then moves to ACCESS.
  - With no valid request it stays in IDLE.
- **ACCESS** (exactly one cycle)
  - If `addr < DEPTH`: assert `mem_we_o = we` and `mem_re_o = !we`; `mem_addr_o` and `mem_wdata_o` carry the captured values.
  - If `addr >= DEPTH`: no strobe is asserted and an error flag is latched.
  - Next state is RESP.
- **RESP** (exactly one cycle)
  - Pulse `rspN_valid_o` on the captured port only.
  - `rspN_rdata_o` is `mem_rdata_i` for an in-range read; it is 0 for writes and errors.
  - `rspN_err_o = 1` iff the address was out of range.
  - Next state is IDLE.
- Outputs when not actively driven: all `ready`, `rsp_valid`, `err` and `mem_*` outputs are 0, and the data buses are 0.
- Requesters must hold `valid` and their payload stable until `ready`. The arbiter may switch its pick while no handshake has occurred.
- Reset, including mid-transaction:
  - State returns to IDLE and every output goes to 0.
  - Any in-flight response is dropped and never issued.
  - The priority pointer returns to port 0.

## Timing
- Handshake at rising edge T, strobe during cycle T+1, response during cycle T+2.
- Earliest next handshake is edge T+3; peak throughput is 1 request per 3 cycles.
- Never more than one outstanding request. Responses return in request order.
- No combinational path from `mem_rdata_i` to anything except `rspN_rdata_o` in RESP.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration.
  - When both ports are valid, the port not granted last wins.
  - The pointer updates only on a handshake. After reset, port 0 has priority.
- `DMEM_ARB_RR_EN` undefined: fixed priority, port 0 always wins. Port 1 can starve.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum (IDLE/ACCESS/RESP);
  - port-ID localparams (`PORT_CPU = 0`, `PORT_LDR = 1`);
  - the default `DEPTH` constant.
- One sub-module, `rr_arbiter2`:
  - 2-input grant logic plus the priority-pointer flop;
  - contains the `DMEM_ARB_RR_EN` switch.
- The FSM and capture registers live in `dmem_arbiter`.

## Test plan
- **Single read:** port 0 reads addr 3, memory preloaded with 0xDEADBEEF → `mem_re_o` high one cycle later, then `rsp0_valid_o` with 0xDEADBEEF and `err = 0` two cycles after the handshake.
- **Write then read:** port 1 writes 0x12345678 to addr 5, then reads addr 5 → one `mem_we_o` pulse, a write response with rdata 0, then read data 0x12345678.
- **Contention:** both ports hold valid for 4 transactions.
  - RR build: grant order 0,1,0,1.
  - Non-RR build: 0,0,0,0, with port 1 still waiting.
- **Out of range:** read addr 8 → no `mem_*` strobe, `rsp_err_o = 1`, rdata 0, FSM back in IDLE at T+3.
- **Reset mid-op:** drop `rst_n` during ACCESS → all outputs 0 immediately (asynchronously), no response pulse after release, and the next contended grant goes to port 0.
- **Back-to-back:** port 0 holds valid continuously for 3 reads → handshakes exactly 3 cycles apart, with `ready` low in ACCESS and RESP.
